// File: rtl/dht11_read_scheduler_pkg.sv
// Shared types and constants for the DHT11 read scheduler.
// Optional statistics counters are enabled with DHT_SCHED_STATS_EN.
package dht11_read_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_FAIL  = 3'd5
  } state_e;

  localparam int MS_W    = 16;  // ms counters (PERIOD_MS up to 65535)
  localparam int RETRY_W = 3;   // MAX_RETRY 0..7
  localparam int DATA_W  = 8;
  localparam int STAT_W  = 16;

  // Prescaler division for a 1 ms tick (MS_DIV = CLK_HZ/1000), never below 1.
  function automatic int ms_div(input int clk_hz);
    return (clk_hz / 1000 > 1) ? clk_hz / 1000 : 1;
  endfunction

endpackage

// File: rtl/dht11_read_scheduler_if.sv
// Bus between the button/auto logic, the DHT11 controller and the display side.
// good_cnt/fail_cnt exist only when DHT_SCHED_STATS_EN is defined.
interface dht11_read_scheduler_if;
  import dht11_read_scheduler_pkg::*;

  logic              auto_en;
  logic              manual_req;
  logic              dht_start;
  logic              dht_done;
  logic              dht_valid;
  logic [DATA_W-1:0] rh_in;
  logic [DATA_W-1:0] t_in;
  logic [DATA_W-1:0] rh_out;
  logic [DATA_W-1:0] t_out;
  logic              data_upd;
  logic              busy;
  logic              err;
`ifdef DHT_SCHED_STATS_EN
  logic [STAT_W-1:0] good_cnt;
  logic [STAT_W-1:0] fail_cnt;
`endif

  modport master (
    output auto_en, manual_req, dht_done, dht_valid, rh_in, t_in,
`ifdef DHT_SCHED_STATS_EN
    input  good_cnt, fail_cnt,
`endif
    input  dht_start, rh_out, t_out, data_upd, busy, err
  );

  modport slave (
    input  auto_en, manual_req, dht_done, dht_valid, rh_in, t_in,
`ifdef DHT_SCHED_STATS_EN
    output good_cnt, fail_cnt,
`endif
    output dht_start, rh_out, t_out, data_upd, busy, err
  );

endinterface

// File: rtl/dht11_read_scheduler_ms_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
module dht11_read_scheduler_ms_tick_gen #(
  parameter int DIV = 100_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          tick_q;

  // Count 0..DIV-1 and pulse the tick on wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (cnt_q == LAST) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/dht11_read_scheduler.sv
// DHT11 read scheduler: periodic/manual read starts, 2 s sensor gap,
// timeout + retry, last-good data latch. Define DHT_SCHED_STATS_EN to add
// saturating good/fail read counters.
module dht11_read_scheduler
  import dht11_read_scheduler_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PERIOD_MS  = 5000,
  parameter int MIN_GAP_MS = 2000,
  parameter int TIMEOUT_MS = 50,
  parameter int MAX_RETRY  = 3
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  dht11_read_scheduler_if.slave bus
);

  localparam logic [MS_W-1:0]    PERIOD_C = MS_W'(PERIOD_MS);
  localparam logic [MS_W-1:0]    GAP_C    = MS_W'(MIN_GAP_MS);
  localparam logic [MS_W-1:0]    TO_C     = MS_W'(TIMEOUT_MS);
  localparam logic [RETRY_W-1:0] RETRY_C  = RETRY_W'(MAX_RETRY);

  logic tick;

  dht11_read_scheduler_ms_tick_gen #(.DIV(ms_div(CLK_HZ))) u_tick (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .tick_o (tick)
  );

  state_e             state_q;
  logic [RETRY_W-1:0] retry_q;
  logic [MS_W-1:0]    gap_q, gap_d;
  logic [MS_W-1:0]    period_q, period_d;
  logic [MS_W-1:0]    to_q, to_d;
  logic               cap_valid_q;
  logic [DATA_W-1:0]  cap_rh_q, cap_t_q;
  logic [DATA_W-1:0]  rh_q, t_q;
  logic               start_q, upd_q, busy_q, err_q;

  // ms counters: cleared while the start pulse is out, otherwise count ticks
  // up to their saturation value.
  always_comb begin
    gap_d    = gap_q;
    period_d = period_q;
    to_d     = to_q;
    if (start_q) begin
      gap_d    = '0;
      period_d = '0;
      to_d     = '0;
    end else if (tick) begin
      if (gap_q < GAP_C)       gap_d    = gap_q + 1'b1;
      if (period_q < PERIOD_C) period_d = period_q + 1'b1;
      if (to_q < TO_C)         to_d     = to_q + 1'b1;
    end
  end

  // Counter registers; gap preloaded so the first read may start at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gap_q    <= GAP_C;
      period_q <= '0;
      to_q     <= '0;
    end else begin
      gap_q    <= gap_d;
      period_q <= period_d;
      to_q     <= to_d;
    end
  end

  // Read sequencer with registered outputs; requests arriving outside IDLE
  // are dropped, and busy covers START through CHECK including retry waits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      retry_q     <= '0;
      cap_valid_q <= 1'b0;
      cap_rh_q    <= '0;
      cap_t_q     <= '0;
      rh_q        <= '0;
      t_q         <= '0;
      start_q     <= 1'b0;
      upd_q       <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      start_q <= 1'b0;
      upd_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.manual_req || (bus.auto_en && period_q == PERIOD_C))
            state_q <= S_ARM;
        end
        S_ARM: begin
          if (gap_q == GAP_C) begin
            state_q <= S_START;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          if (bus.dht_done) begin
            cap_valid_q <= bus.dht_valid;
            cap_rh_q    <= bus.rh_in;
            cap_t_q     <= bus.t_in;
            state_q     <= S_CHECK;
          end else if (to_q == TO_C) begin
            state_q <= S_FAIL;
          end
        end
        S_CHECK: begin
          if (cap_valid_q) begin
            rh_q    <= cap_rh_q;
            t_q     <= cap_t_q;
            upd_q   <= 1'b1;
            err_q   <= 1'b0;
            retry_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            state_q <= S_FAIL;
          end
        end
        S_FAIL: begin
          if (retry_q < RETRY_C) begin
            retry_q <= retry_q + 1'b1;
            state_q <= S_ARM;
          end else begin
            err_q   <= 1'b1;
            retry_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.dht_start = start_q;
  assign bus.rh_out    = rh_q;
  assign bus.t_out     = t_q;
  assign bus.data_upd  = upd_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

`ifdef DHT_SCHED_STATS_EN
  logic [STAT_W-1:0] good_q, fail_q;

  // Saturating counts of good reads (CHECK with valid) and FAIL entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      good_q <= '0;
      fail_q <= '0;
    end else begin
      if (state_q == S_CHECK && cap_valid_q && good_q != '1) good_q <= good_q + 1'b1;
      if (state_q == S_FAIL && fail_q != '1)                 fail_q <= fail_q + 1'b1;
    end
  end

  assign bus.good_cnt = good_q;
  assign bus.fail_cnt = fail_q;
`endif

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Directed bench for dht11_read_scheduler at 10 cycles/ms.
module tb_dht11_read_scheduler;
  import dht11_read_scheduler_pkg::*;

  localparam int CLK_HZ     = 10_000;
  localparam int PERIOD_MS  = 20;
  localparam int MIN_GAP_MS = 8;
  localparam int TIMEOUT_MS = 5;
  localparam int MAX_RETRY  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dht11_read_scheduler_if bus();

  dht11_read_scheduler #(
    .CLK_HZ(CLK_HZ), .PERIOD_MS(PERIOD_MS), .MIN_GAP_MS(MIN_GAP_MS),
    .TIMEOUT_MS(TIMEOUT_MS), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Monitor: cycle index, start-pulse cycles, update-pulse cycles.
  int cyc = 0, n_start = 0, last_start = 0, n_upd = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && bus.dht_start) begin
      n_start    <= n_start + 1;
      last_start <= cyc + 1;
    end
    if (rst_n && bus.data_upd) n_upd <= n_upd + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(output int rq);
    @(posedge clk); #1 bus.manual_req = 1'b1;
    @(negedge clk); #1 rq = cyc;
    @(posedge clk); #1 bus.manual_req = 1'b0;
  endtask

  task automatic pulse_done(input int extra, input logic v, input logic [7:0] rh, input logic [7:0] t);
    repeat (extra) @(posedge clk);
    @(posedge clk); #1;
    bus.dht_done = 1'b1; bus.dht_valid = v; bus.rh_in = rh; bus.t_in = t;
    @(posedge clk); #1;
    bus.dht_done = 1'b0; bus.dht_valid = 1'b0;
  endtask

  task automatic wait_start(input int n0, input int budget, input string nm);
    int k = 0;
    while (n_start <= n0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (n_start <= n0) begin
      n_chk++;
      $display("FAIL %s: no dht_start within %0d cycles", nm, budget);
    end
  endtask

  typedef struct {
    logic [7:0] rh_in;
    logic [7:0] t_in;
    int         dly;
    logic [7:0] exp_rh;
    logic [7:0] exp_t;
  } vec_t;

  vec_t tbl[4];

  initial begin
    int rq, dummy, n0, n1, u0, s;
    bus.auto_en = 1'b0; bus.manual_req = 1'b0; bus.dht_done = 1'b0;
    bus.dht_valid = 1'b0; bus.rh_in = '0; bus.t_in = '0;

    tbl[0] = '{8'h37, 8'h19, 30, 8'h37, 8'h19};
    tbl[1] = '{8'hFF, 8'hFF,  0, 8'hFF, 8'hFF};
    tbl[2] = '{8'h00, 8'h80, 38, 8'h00, 8'h80};
    tbl[3] = '{8'h5A, 8'hA5, 10, 8'h5A, 8'hA5};

    // Reset state
    step(3);
    chk("rst_rh", bus.rh_out, 0);
    chk("rst_t", bus.t_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_start", bus.dht_start, 0);
    rst_n = 1'b1;

    // Manual reads with good data; the first comes straight after reset.
    for (int i = 0; i < 4; i++) begin
      if (i != 0) step(100);
      n0 = n_start; u0 = n_upd;
      pulse_req(rq);
      wait_start(n0, 6, "tbl_start");
      chk("tbl_latency", last_start - rq, 2);
      chk("tbl_busy_wait", bus.busy, 1);
      pulse_done(tbl[i].dly, 1'b1, tbl[i].rh_in, tbl[i].t_in);
      step(4);
      chk("tbl_rh", bus.rh_out, tbl[i].exp_rh);
      chk("tbl_t", bus.t_out, tbl[i].exp_t);
      chk("tbl_upd", n_upd - u0, 1);
      chk("tbl_busy_end", bus.busy, 0);
      chk("tbl_err", bus.err, 0);
      chk("tbl_nstart", n_start - n0, 1);
    end

    // manual_req while busy and dht_done while idle are both ignored.
    step(100);
    n0 = n_start; u0 = n_upd;
    pulse_req(rq);
    wait_start(n0, 6, "ign_start");
    pulse_req(dummy);
    pulse_done(5, 1'b1, 8'h42, 8'h24);
    step(4);
    pulse_done(0, 1'b1, 8'h99, 8'h99);
    step(100);
    chk("ign_rh", bus.rh_out, 8'h42);
    chk("ign_t", bus.t_out, 8'h24);
    chk("ign_nstart", n_start - n0, 1);
    chk("ign_upd", n_upd - u0, 1);

    // Auto mode: one start per ~200 cycles; disable mid-read stops further reads.
    step(100);
    n0 = n_start;
    bus.auto_en = 1'b1;
    wait_start(n0, 20, "auto_first");
    for (int k = 0; k < 3; k++) begin
      s = last_start; n1 = n_start;
      pulse_done(5, 1'b1, 8'(8'h50 + k), 8'(8'h20 + k));
      wait_start(n1, 230, "auto_next");
      chk_rng("auto_interval", last_start - s, 190, 210);
      chk("auto_one_pulse", n_start - n1, 1);
      chk("auto_rh", bus.rh_out, 8'(8'h50 + k));
    end
    bus.auto_en = 1'b0;
    n1 = n_start;
    pulse_done(5, 1'b1, 8'h5F, 8'h2F);
    step(300);
    chk("auto_off_nstart", n_start - n1, 0);
    chk("auto_off_rh", bus.rh_out, 8'h5F);

    // Gap enforcement: request 3 ms after a start is held to 8 ms; a second
    // request while armed adds nothing.
    step(100);
    n0 = n_start;
    pulse_req(rq);
    wait_start(n0, 6, "gap_first");
    s = last_start;
    pulse_done(3, 1'b1, 8'h61, 8'h16);
    step(20);
    n1 = n_start;
    pulse_req(rq);
    step(20);
    pulse_req(dummy);
    wait_start(n1, 100, "gap_start");
    chk_rng("gap_hold", last_start - s, 70, 85);
    pulse_done(2, 1'b1, 8'h62, 8'h26);
    step(120);
    chk("gap_single", n_start - n1, 1);
    chk("gap_rh", bus.rh_out, 8'h62);

    // Two invalid frames then a valid one.
    step(100);
    n0 = n_start; u0 = n_upd;
    pulse_req(rq);
    wait_start(n0, 6, "inv_s1");
    pulse_done(2, 1'b0, 8'hEE, 8'hEE);
    step(4);
    chk("inv1_err", bus.err, 0);
    chk("inv1_rh", bus.rh_out, 8'h62);
    chk("inv1_busy", bus.busy, 1);
    wait_start(n0 + 1, 100, "inv_s2");
    pulse_done(2, 1'b0, 8'hEE, 8'hEE);
    step(4);
    chk("inv2_err", bus.err, 0);
    chk("inv2_t", bus.t_out, 8'h26);
    wait_start(n0 + 2, 100, "inv_s3");
    pulse_done(2, 1'b1, 8'h11, 8'h22);
    step(4);
    chk("inv3_rh", bus.rh_out, 8'h11);
    chk("inv3_t", bus.t_out, 8'h22);
    chk("inv3_err", bus.err, 0);
    chk("inv3_busy", bus.busy, 0);
    chk("inv3_upd", n_upd - u0, 1);
    step(150);
    chk("inv_nstart", n_start - n0, 3);

    // No dht_done at all: three starts 8 ms apart, then err.
    step(100);
    n0 = n_start; u0 = n_upd;
    pulse_req(rq);
    wait_start(n0, 6, "to_s1");
    s = last_start;
    wait_start(n0 + 1, 100, "to_s2");
    chk_rng("to_space1", last_start - s, 70, 85);
    s = last_start;
    wait_start(n0 + 2, 100, "to_s3");
    chk_rng("to_space2", last_start - s, 70, 85);
    begin
      int k = 0;
      while (!bus.err && k < 80) begin step(1); k++; end
    end
    chk("to_err", bus.err, 1);
    step(150);
    chk("to_nstart", n_start - n0, 3);
    chk("to_rh", bus.rh_out, 8'h11);
    chk("to_t", bus.t_out, 8'h22);
    chk("to_busy", bus.busy, 0);
    chk("to_upd", n_upd - u0, 0);

    // A good read clears err.
    step(100);
    n0 = n_start;
    pulse_req(rq);
    wait_start(n0, 6, "clr_start");
    pulse_done(1, 1'b1, 8'h33, 8'h44);
    step(4);
    chk("clr_err", bus.err, 0);
    chk("clr_rh", bus.rh_out, 8'h33);

`ifdef DHT_SCHED_STATS_EN
    chk("stat_good", bus.good_cnt, 13);
    chk("stat_fail", bus.fail_cnt, 5);
`endif

    // Reset in the middle of WAIT, then a stale done after release.
    step(100);
    n0 = n_start;
    pulse_req(rq);
    wait_start(n0, 6, "rst_start");
    step(10);
    chk("mid_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rh", bus.rh_out, 0);
    chk("mid_rst_t", bus.t_out, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_start", bus.dht_start, 0);
`ifdef DHT_SCHED_STATS_EN
    chk("mid_rst_good", bus.good_cnt, 0);
    chk("mid_rst_fail", bus.fail_cnt, 0);
`endif
    step(3);
    rst_n = 1'b1;
    u0 = n_upd;
    pulse_done(1, 1'b1, 8'h77, 8'h77);
    step(5);
    chk("stale_rh", bus.rh_out, 0);
    chk("stale_upd", n_upd - u0, 0);
    chk("stale_busy", bus.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Runaway guard.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
